// File: rtl/qm_icache_pkg.sv
// Shared constants for the direct-mapped instruction cache: FSM encodings,
// memory-controller command opcode and the tag-width derivation.
package qm_icache_pkg;

  typedef logic [1:0] qm_state_t;

  localparam qm_state_t ST_SWEEP = 2'd0;
  localparam qm_state_t ST_IDLE  = 2'd1;
  localparam qm_state_t ST_CMD   = 2'd2;
  localparam qm_state_t ST_FILL  = 2'd3;

  localparam logic [2:0] QM_MEM_CMD_READ = 3'b001;

  // Tag covers everything above the word and index fields of a 32-bit byte address.
  function automatic int qm_tag_bits(input int index_bits, input int word_bits);
    return 30 - index_bits - word_bits;
  endfunction

endpackage

// File: rtl/qm_icache_tagstore.sv
// Valid/tag storage: combinational read port, one write port for line
// commit, and a clear-by-index port driven by the invalidate sweep.
module qm_icache_tagstore #(
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS   = 20
) (
  input  logic                  clk,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  input  logic                  wr_en_i,
  input  logic [INDEX_BITS-1:0] wr_idx_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic                  clr_en_i,
  input  logic [INDEX_BITS-1:0] clr_idx_i
);

  localparam int SETS = 1 << INDEX_BITS;

  logic [SETS-1:0]     valid_q;
  logic [TAG_BITS-1:0] tag_q [SETS];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];

  // Sweep clears one set per cycle; a commit sets valid and records the tag.
  // The two never overlap since sweep and fill are distinct FSM states.
  always_ff @(posedge clk) begin
    if (clr_en_i) valid_q[clr_idx_i] <= 1'b0;
    if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      tag_q[wr_idx_i]   <= wr_tag_i;
    end
  end

endmodule

// File: rtl/qm_icache_dm.sv
// Direct-mapped instruction cache. Hits are combinational; a miss issues one
// burst read for the whole line and stalls fetch until the line commits.
// Flush and reset both run a one-set-per-cycle invalidate sweep.
module qm_icache_dm
  import qm_icache_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int WORD_BITS  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        req,
  input  logic        flush,
  output logic        hit,
  output logic        stall,
  output logic [31:0] data,
  output logic        mem_cmd_clk,
  output logic        mem_rd_clk,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_addr,
  input  logic        mem_cmd_full,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_empty
);

  localparam int TAG_BITS  = qm_tag_bits(INDEX_BITS, WORD_BITS);
  localparam int SETS      = 1 << INDEX_BITS;
  localparam int WORDS     = 1 << WORD_BITS;
  localparam int LINE_BITS = 30 - WORD_BITS;

  localparam logic [INDEX_BITS-1:0] CNT_LAST = '1;
  localparam logic [WORD_BITS-1:0]  K_LAST   = '1;
  localparam logic [5:0]            CMD_BL   = 6'(WORDS - 1);

  qm_state_t             state_q, state_d;
  logic [INDEX_BITS-1:0] cnt_q, cnt_d;
  logic [WORD_BITS-1:0]  k_q, k_d;
  logic                  pend_q, pend_d;
  logic [LINE_BITS-1:0]  miss_line_q, miss_line_d;

  logic [31:0] data_q [SETS][WORDS];

  logic [WORD_BITS-1:0]  lk_word;
  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic [INDEX_BITS-1:0] miss_idx;
  logic [TAG_BITS-1:0]   miss_tag;
  logic                  ts_valid;
  logic [TAG_BITS-1:0]   ts_tag;
  logic                  lookup_hit;
  logic                  sweep_clr, fill_we, tag_we, cmd_push, rd_pop;
  logic                  unused_addr_bits;

  assign lk_word  = address[WORD_BITS+1:2];
  assign lk_idx   = address[INDEX_BITS+WORD_BITS+1:WORD_BITS+2];
  assign lk_tag   = address[31:32-TAG_BITS];
  assign miss_idx = miss_line_q[INDEX_BITS-1:0];
  assign miss_tag = miss_line_q[LINE_BITS-1:INDEX_BITS];
  assign unused_addr_bits = ^address[1:0];

  qm_icache_tagstore #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_tagstore (
    .clk       (clk),
    .rd_idx_i  (lk_idx),
    .rd_valid_o(ts_valid),
    .rd_tag_o  (ts_tag),
    .wr_en_i   (tag_we && !reset),
    .wr_idx_i  (miss_idx),
    .wr_tag_i  (miss_tag),
    .clr_en_i  (sweep_clr),
    .clr_idx_i (cnt_q)
  );

  // Lookup is only meaningful in IDLE; outputs are forced quiet while reset is high.
  assign lookup_hit = !reset && (state_q == ST_IDLE) && req && ts_valid && (ts_tag == lk_tag);
  assign hit        = lookup_hit;
  assign stall      = reset || (state_q != ST_IDLE) || (req && !lookup_hit);
  assign data       = lookup_hit ? data_q[lk_idx][lk_word] : 32'h0;

  assign mem_cmd_clk   = clk;
  assign mem_rd_clk    = clk;
  assign mem_cmd_en    = cmd_push && !reset;
  assign mem_cmd_instr = mem_cmd_en ? QM_MEM_CMD_READ : 3'b000;
  assign mem_cmd_bl    = CMD_BL;
  assign mem_cmd_addr  = {miss_line_q[LINE_BITS-3:0], {(WORD_BITS+2){1'b0}}};
  assign mem_rd_en     = rd_pop && !reset;

  // Next-state logic for sweep / lookup / command / fill sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    pend_d      = pend_q;
    miss_line_d = miss_line_q;
    sweep_clr   = 1'b0;
    fill_we     = 1'b0;
    tag_we      = 1'b0;
    cmd_push    = 1'b0;
    rd_pop      = 1'b0;
    case (state_q)
      ST_SWEEP: begin
        sweep_clr = 1'b1;
        if (flush) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (flush) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end else if (req && !lookup_hit) begin
          state_d     = ST_CMD;
          miss_line_d = address[31:WORD_BITS+2];
          k_d         = '0;
        end
      end
      ST_CMD: begin
        cmd_push = !mem_cmd_full;
        if (flush) pend_d = 1'b1;
        if (!mem_cmd_full) state_d = ST_FILL;
      end
      ST_FILL: begin
        rd_pop = 1'b1;
        if (flush) pend_d = 1'b1;
        if (!mem_rd_empty) begin
          fill_we = 1'b1;
          k_d     = k_q + 1'b1;
          if (k_q == K_LAST) begin
            tag_we = 1'b1;
            // A flush seen at any point during the miss runs once the line is in.
            if (pend_q || flush) begin
              state_d = ST_SWEEP;
              cnt_d   = '0;
              pend_d  = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_SWEEP;
        cnt_d   = '0;
      end
    endcase
  end

  // Control registers; reset restarts the sweep and drops any in-flight miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SWEEP;
      cnt_q       <= '0;
      k_q         <= '0;
      pend_q      <= 1'b0;
      miss_line_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      pend_q      <= pend_d;
      miss_line_q <= miss_line_d;
    end
  end

  // Line data array; validity lives in the tag store, so no reset here.
  always_ff @(posedge clk) begin
    if (fill_we && !reset) data_q[miss_idx][k_q] <= mem_rd_data;
  end

endmodule

// File: tb/tb_qm_icache_dm.sv
// Self-checking bench for qm_icache_dm (4-bit index, 4-word lines) with a
// behavioural memory controller and an expected-data scoreboard.
module tb_qm_icache_dm;

  localparam int IB = 4;
  localparam int WB = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] address = 32'h0;
  logic        mem_cmd_full = 1'b0;
  logic [31:0] mem_rd_data = 32'h0;
  logic        empty_q = 1'b1;
  logic        empty_force = 1'b0;
  wire         mem_rd_empty = empty_q | empty_force;

  wire         hit, stall, mem_cmd_clk, mem_rd_clk, mem_cmd_en, mem_rd_en;
  wire [31:0]  data;
  wire [2:0]   mem_cmd_instr;
  wire [5:0]   mem_cmd_bl;
  wire [29:0]  mem_cmd_addr;

  always #5 clk = ~clk;

  qm_icache_dm #(.INDEX_BITS(IB), .WORD_BITS(WB)) dut (
    .clk(clk), .reset(reset), .address(address), .req(req), .flush(flush),
    .hit(hit), .stall(stall), .data(data),
    .mem_cmd_clk(mem_cmd_clk), .mem_rd_clk(mem_rd_clk),
    .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_full(mem_cmd_full),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data), .mem_rd_empty(mem_rd_empty)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rd_fifo[$];
  logic [31:0] pop_log[$];
  int          cmd_count = 0;
  int          pop_count = 0;
  logic [29:0] last_cmd_addr = '0;
  logic [5:0]  last_bl = '0;
  logic [2:0]  last_instr = '0;

  // Reference memory contents: one recognisable line, everything else address-derived.
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (a[31:4] == 28'h000_0123) return 32'hA0 + 32'(a[3:2]);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  // Memory controller model: handshakes observed at the edge, FIFO head driven mid-cycle.
  always @(posedge clk) begin
    if (!reset) begin
      if (mem_cmd_en && !mem_cmd_full) begin
        cmd_count++;
        last_cmd_addr = mem_cmd_addr;
        last_bl = mem_cmd_bl;
        last_instr = mem_cmd_instr;
        for (int j = 0; j <= int'(mem_cmd_bl); j++)
          rd_fifo.push_back(ref_word({2'b00, mem_cmd_addr} + 32'(4 * j)));
      end
      if (mem_rd_en && !mem_rd_empty && rd_fifo.size() > 0) begin
        pop_log.push_back(rd_fifo.pop_front());
        pop_count++;
      end
    end
  end

  always @(negedge clk) begin
    empty_q = (rd_fifo.size() == 0);
    mem_rd_data = empty_q ? 32'hDEAD_BEEF : rd_fifo[0];
  end

  task automatic present(input logic [31:0] a);
    @(negedge clk);
    address = a;
    req = 1'b1;
    #1;
  endtask

  // Hold the request until hit (or budget expires), shaping FIFO backpressure per cycle.
  task automatic wait_hit(input int max_cyc, input int full_cyc, input bit toggle_empty, output int cyc);
    cyc = 0;
    mem_cmd_full = (full_cyc > 0);
    empty_force = toggle_empty;
    #1;
    while (!hit && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      mem_cmd_full = (cyc < full_cyc);
      empty_force = toggle_empty && (cyc % 2 == 0);
      #1;
    end
    mem_cmd_full = 1'b0;
    empty_force = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    int n;
    int cyc;
    logic [31:0] want;
    repeat (2) @(negedge clk);
    #1;
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b want=0", hit); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall got=%b want=1", stall); end
    total++; if (data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", data); end
    total++; if ({mem_cmd_en, mem_rd_en, mem_cmd_instr} !== 5'b0) begin
      bad++; $display("FAIL reset_mem_outs got=%b%b%b want=00000", mem_cmd_en, mem_rd_en, mem_cmd_instr);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n = 0;
    while (stall && n < 100) begin n++; @(negedge clk); #1; end
    total++; if (n !== 16) begin bad++; $display("FAIL reset_sweep_len got=%0d want=16", n); end
    present(32'h0);
    total++; if ({hit, stall} !== 2'b01) begin bad++; $display("FAIL post_reset_miss got=%b%b want=01", hit, stall); end
    exp_q.push_back(ref_word(32'h0));
    wait_hit(40, 0, 1'b0, cyc);
    want = exp_q.pop_front();
    total++; if (!hit || data !== want) begin bad++; $display("FAIL line0_fill got=%b/%h want=1/%h", hit, data, want); end
  endtask

  task automatic test_cold_miss();
    int c0;
    int cyc;
    logic [31:0] want;
    c0 = cmd_count;
    present(32'h0000_1234);
    total++; if ({hit, stall} !== 2'b01) begin bad++; $display("FAIL cold_first_cycle got=%b%b want=01", hit, stall); end
    exp_q.push_back(32'hA1);
    wait_hit(40, 0, 1'b0, cyc);
    total++; if (cyc !== 6) begin bad++; $display("FAIL cold_latency got=%0d want=6", cyc); end
    want = exp_q.pop_front();
    total++; if (!hit || data !== want) begin bad++; $display("FAIL cold_data got=%b/%h want=1/%h", hit, data, want); end
    total++; if (cmd_count - c0 !== 1) begin bad++; $display("FAIL cold_cmd_count got=%0d want=1", cmd_count - c0); end
    total++; if (last_cmd_addr !== 30'h0000_1230) begin bad++; $display("FAIL cold_cmd_addr got=%h want=1230", last_cmd_addr); end
    total++; if (last_bl !== 6'd3) begin bad++; $display("FAIL cold_cmd_bl got=%0d want=3", last_bl); end
    total++; if (last_instr !== 3'b001) begin bad++; $display("FAIL cold_cmd_instr got=%b want=001", last_instr); end
    // Back-to-back zero-latency hits on the filled line.
    for (int i = 0; i < 2; i++) begin
      present(32'h0000_1230 + 32'(8 * i));
      exp_q.push_back(32'hA0 + 32'(2 * i));
      want = exp_q.pop_front();
      total++; if ({hit, stall} !== 2'b10 || data !== want) begin
        bad++; $display("FAIL warm_hit%0d got=%b%b/%h want=10/%h", i, hit, stall, data, want);
      end
    end
  endtask

  task automatic test_conflict();
    int cyc;
    logic [31:0] want;
    present(32'h0001_1230);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL conflict_miss got=%b want=0", hit); end
    exp_q.push_back(ref_word(32'h0001_1230));
    wait_hit(40, 0, 1'b0, cyc);
    want = exp_q.pop_front();
    total++; if (!hit || data !== want) begin bad++; $display("FAIL conflict_data got=%b/%h want=1/%h", hit, data, want); end
    total++; if (last_cmd_addr !== 30'h0001_1230) begin bad++; $display("FAIL conflict_cmd_addr got=%h want=11230", last_cmd_addr); end
    present(32'h0000_1234);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL evicted_miss got=%b want=0", hit); end
    exp_q.push_back(32'hA1);
    wait_hit(40, 0, 1'b0, cyc);
    want = exp_q.pop_front();
    total++; if (!hit || data !== want) begin bad++; $display("FAIL refill_data got=%b/%h want=1/%h", hit, data, want); end
  endtask

  task automatic test_backpressure();
    int c0;
    int p0;
    int cyc;
    logic [31:0] want;
    c0 = cmd_count;
    p0 = pop_log.size();
    present(32'h0000_2470);
    wait_hit(80, 5, 1'b1, cyc);
    total++; if (!hit) begin bad++; $display("FAIL bp_timeout got=%0d cycles want=hit", cyc); end
    total++; if (cmd_count - c0 !== 1) begin bad++; $display("FAIL bp_cmd_count got=%0d want=1", cmd_count - c0); end
    total++; if (pop_log.size() - p0 !== 4) begin bad++; $display("FAIL bp_pop_count got=%0d want=4", pop_log.size() - p0); end
    for (int i = 0; i < 4; i++) begin
      want = ref_word(32'h0000_2470 + 32'(4 * i));
      total++; if (pop_log.size() <= p0 + i || pop_log[p0 + i] !== want) begin
        bad++; $display("FAIL bp_pop_order%0d want=%h", i, want);
      end
    end
    for (int i = 0; i < 4; i++) begin
      present(32'h0000_2470 + 32'(4 * i));
      exp_q.push_back(ref_word(32'h0000_2470 + 32'(4 * i)));
      want = exp_q.pop_front();
      total++; if (!hit || data !== want) begin bad++; $display("FAIL bp_line%0d got=%b/%h want=1/%h", i, hit, data, want); end
    end
  endtask

  task automatic test_addr_change();
    int c0;
    int cyc;
    logic [31:0] want;
    c0 = cmd_count;
    present(32'h0000_3450);
    repeat (3) @(negedge clk);
    address = 32'h0000_3464;
    exp_q.push_back(ref_word(32'h0000_3464));
    #1;
    wait_hit(60, 0, 1'b0, cyc);
    want = exp_q.pop_front();
    total++; if (!hit || data !== want) begin bad++; $display("FAIL redirect_data got=%b/%h want=1/%h", hit, data, want); end
    total++; if (cmd_count - c0 !== 2) begin bad++; $display("FAIL redirect_cmds got=%0d want=2", cmd_count - c0); end
    total++; if (last_cmd_addr !== 30'h0000_3460) begin bad++; $display("FAIL redirect_cmd_addr got=%h want=3460", last_cmd_addr); end
    present(32'h0000_3450);
    exp_q.push_back(ref_word(32'h0000_3450));
    want = exp_q.pop_front();
    total++; if (!hit || data !== want) begin bad++; $display("FAIL orig_line_hit got=%b/%h want=1/%h", hit, data, want); end
  endtask

  task automatic test_flush_fill();
    int c0;
    int p0;
    int n;
    int cyc;
    logic [31:0] want;
    c0 = cmd_count;
    p0 = pop_count;
    present(32'h0000_56A0);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    req = 1'b0;
    #1;
    n = 0;
    while (stall && n < 80) begin n++; @(negedge clk); #1; end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_timeout got=stall want=idle"); end
    total++; if (n < 16) begin bad++; $display("FAIL flush_sweep_len got=%0d want>=16", n); end
    total++; if (pop_count - p0 !== 4) begin bad++; $display("FAIL flush_fill_words got=%0d want=4", pop_count - p0); end
    total++; if (cmd_count - c0 !== 1) begin bad++; $display("FAIL flush_cmds got=%0d want=1", cmd_count - c0); end
    present(32'h0000_56A0);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL flushed_line_miss got=%b want=0", hit); end
    exp_q.push_back(ref_word(32'h0000_56A0));
    wait_hit(40, 0, 1'b0, cyc);
    want = exp_q.pop_front();
    total++; if (!hit || data !== want) begin bad++; $display("FAIL flush_refill got=%b/%h want=1/%h", hit, data, want); end
    present(32'h0000_1230);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL flushed_old_miss got=%b want=0", hit); end
    exp_q.push_back(32'hA0);
    wait_hit(40, 0, 1'b0, cyc);
    want = exp_q.pop_front();
    total++; if (!hit || data !== want) begin bad++; $display("FAIL flush_old_refill got=%b/%h want=1/%h", hit, data, want); end
  endtask

  task automatic test_idle_flush();
    int n;
    @(negedge clk);
    req = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n = 0;
    while (stall && n < 100) begin n++; @(negedge clk); #1; end
    total++; if (n !== 16) begin bad++; $display("FAIL idle_flush_len got=%0d want=16", n); end
    present(32'h0000_1234);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL idle_flush_miss got=%b want=0", hit); end
    req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_backpressure();
    test_addr_change();
    test_flush_fill();
    test_idle_flush();
    repeat (12) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
